boreal_stim_scheduler: RTL and testbench
========================================

// Module: boreal_stim_scheduler
// PURPOSE
//  Gates and sequences closed-loop stimulation from the phase tracker's peak trigger onto stim_out.
//  Accepts a trigger only when armed, phase-locked, confident, safety tier 0 and pulse budget remains.
//  Emits a fixed-width pulse, then enforces a refractory period and a per-window pulse budget.
//  Sits between the PLL tracker / safety tiers and the stim pin; exposes counters for telemetry.
// PARAMETERS
//  PW_CYC      20000      stim pulse width in clk cycles (200 us @ 100 MHz), >=1
//  REFRAC_CYC  10000000   refractory after pulse end, clk cycles (100 ms), >=1
//  WIN_CYC     100000000  budget window length, clk cycles (1 s), >=2
//  MAX_PULSES  8          pulses allowed per window, 1..255
//  CNT_W       32         width of internal timers; must hold max of the three *_CYC
// PORTS
//  clk          in   1  system clock
//  rst          in   1  synchronous reset, active-high
//  arm          in   1  level; operator enable (bite_n-derived)
//  trigger      in   1  single-cycle peak strobe from phase tracker
//  phase_lock   in   1  PLL lock indicator
//  low_conf     in   1  core low-confidence flag
//  safety_tier  in   2  0 = normal, 1/2/3 = degraded/halt
//  stim_out     out  1  stimulation pulse, registered
//  state        out  3  0 IDLE,1 ARMED,2 PULSE,3 REFRAC,4 LOCKOUT
//  pulse_count  out  8  pulses delivered since reset, saturates at 255
//  drop_count   out  8  triggers rejected while armed (any state but IDLE), saturates at 255
//  budget_left  out  8  pulses remaining in current window
//  lockout      out  1  high while in LOCKOUT
// BEHAVIOUR
//  Reset: state=IDLE, stim_out=0, pulse_count=0, drop_count=0, budget_left=MAX_PULSES, lockout=0, timers=0.
//  All outputs registered; every decision uses inputs sampled at the same rising edge.
//  IDLE: stim_out=0; window timer held at 0; arm=1 -> ARMED, budget_left reloads MAX_PULSES.
//  Window timer: runs in all states except IDLE; at count WIN_CYC-1 wraps to 0 and budget_left<=MAX_PULSES.
//  ARMED: trigger accepted iff phase_lock & !low_conf & tier==0 & budget_left!=0.
//   Accept at edge t -> state=PULSE, stim_out=1 from t+1, budget_left-1, pulse_count+1 (sat).
//   Trigger not accepted -> drop_count+1 (sat); state stays ARMED.
//   Simultaneous window wrap and accept: reload then decrement -> budget_left=MAX_PULSES-1.
//  PULSE: stim_out high exactly PW_CYC cycles, then -> REFRAC with stim_out=0.
//   Trigger during PULSE -> dropped, counted.
//  REFRAC: REFRAC_CYC cycles, stim_out=0, then -> ARMED. Triggers dropped, counted.
//   Trigger on the last REFRAC cycle is still dropped (ARMED only from next edge).
//  Safety: tier!=0 in ARMED/PULSE/REFRAC -> LOCKOUT next edge; stim_out=0 on that edge (pulse truncated).
//  LOCKOUT: lockout=1, stim_out=0, triggers counted as drops. Exit only to IDLE, when arm=0 & tier==0;
//   operator must drop then reassert arm to resume (no direct LOCKOUT->ARMED).
//  arm=0 in any non-LOCKOUT state -> IDLE next edge, stim_out=0 (truncates pulse); timers cleared.
//  Priority at one edge: rst > tier!=0 > arm=0 > timer expiry > trigger.
//  Counters saturate; never wrap. budget_left never underflows.
//  Invariant: stim_out=1 only in PULSE; never high more than PW_CYC consecutive cycles.
// TESTING  (bench params: PW_CYC=4, REFRAC_CYC=10, WIN_CYC=100, MAX_PULSES=2)
//  1 rst, arm=1, lock=1, tier=0, trigger at t -> stim_out high t+1..t+4, state REFRAC t+5..t+14, ARMED t+15.
//  2 triggers at t, t+2, t+8 -> one pulse only; drop_count=2; pulse_count=1.
//  3 three accepted-eligible triggers spaced 20 cycles in one window -> 2 pulses, 3rd dropped, budget_left=0;
//    after window wrap budget_left=2 and next trigger pulses.
//  4 tier=2 at 2nd cycle of pulse -> stim_out low next edge, state LOCKOUT; tier=0 arm=1 stays LOCKOUT;
//    arm=0 -> IDLE; arm=1 -> ARMED.
//  5 phase_lock=0 or low_conf=1 with trigger in ARMED -> no pulse, drop_count+1.
//  6 arm=0 mid-pulse -> stim_out low next edge, IDLE; 300 dropped triggers -> drop_count holds 255.

Source files
------------

// File: rtl/boreal_stim_scheduler.sv
// boreal_stim_scheduler
// Gates peak triggers from the phase tracker onto the stimulation pin.
// A trigger is honoured only while armed, phase-locked, confident, at
// safety tier 0 and with pulse budget left in the current window. Each
// accepted trigger produces one fixed-width pulse followed by a refractory
// period. Telemetry counters report delivered pulses and dropped triggers.
//
// state      | meaning
// -----------+-----------------------------------------------------------
// IDLE    0  | operator disarmed; stim low, window timer held at 0
// ARMED   1  | waiting for an eligible trigger
// PULSE   2  | stim_out high for PW_CYC cycles
// REFRAC  3  | stim low for REFRAC_CYC cycles, triggers dropped
// LOCKOUT 4  | safety halt; leaves only via IDLE (arm low, tier 0)

module boreal_stim_scheduler #(
   parameter int PW_CYC     = 20000,
   parameter int REFRAC_CYC = 10000000,
   parameter int WIN_CYC    = 100000000,
   parameter int MAX_PULSES = 8,
   parameter int CNT_W      = 32
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       arm,
   input  logic       trigger,
   input  logic       phase_lock,
   input  logic       low_conf,
   input  logic [1:0] safety_tier,
   output logic       stim_out,
   output logic [2:0] state,
   output logic [7:0] pulse_count,
   output logic [7:0] drop_count,
   output logic [7:0] budget_left,
   output logic       lockout
);

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_ARMED   = 3'd1,
      ST_PULSE   = 3'd2,
      ST_REFRAC  = 3'd3,
      ST_LOCKOUT = 3'd4
   } state_t;

   // Terminal-count values for the down-counting phase timer and the
   // wrap value of the window timer.
   localparam logic [CNT_W-1:0] PW_LAST     = CNT_W'(PW_CYC - 1);
   localparam logic [CNT_W-1:0] REFRAC_LAST = CNT_W'(REFRAC_CYC - 1);
   localparam logic [CNT_W-1:0] WIN_LAST    = CNT_W'(WIN_CYC - 1);
   localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);
   localparam logic [7:0]       MAX_B       = 8'(MAX_PULSES);

   state_t           st;
   logic [CNT_W-1:0] phase_tmr;
   logic [CNT_W-1:0] win_tmr;

   logic       tier_ok;
   logic       active;
   logic       win_wrap;
   logic [7:0] budget_eff;
   logic       accept;
   logic       drop;
   logic       go_lock;
   logic       go_idle;

   assign state = st;

   // Per-edge decisions, all derived from the same sampled inputs.
   // A window wrap coinciding with an accept reloads first, so the
   // effective budget seen by the accept test is the reloaded one.
   always_comb begin
      tier_ok    = (safety_tier == 2'd0);
      active     = (st == ST_ARMED) || (st == ST_PULSE) || (st == ST_REFRAC);
      win_wrap   = (st != ST_IDLE) && (win_tmr == WIN_LAST);
      budget_eff = win_wrap ? MAX_B : budget_left;
      accept     = (st == ST_ARMED) && arm && tier_ok && trigger &&
                   phase_lock && !low_conf && (budget_eff != 8'd0);
      drop       = trigger && (st != ST_IDLE) && !accept;
      go_lock    = active && !tier_ok;
      go_idle    = active && tier_ok && !arm;
   end

   // Scheduler state, timers, budget and telemetry counters.
   always_ff @(posedge clk) begin
      if (rst) begin
         st          <= ST_IDLE;
         stim_out    <= 1'b0;
         lockout     <= 1'b0;
         pulse_count <= 8'd0;
         drop_count  <= 8'd0;
         budget_left <= MAX_B;
         phase_tmr   <= '0;
         win_tmr     <= '0;
      end else begin
         if (drop && (drop_count != 8'hFF)) begin
            drop_count <= drop_count + 8'd1;
         end
         if (accept && (pulse_count != 8'hFF)) begin
            pulse_count <= pulse_count + 8'd1;
         end

         if ((st == ST_IDLE) || win_wrap) begin
            win_tmr <= '0;
         end else begin
            win_tmr <= win_tmr + CNT_ONE;
         end

         if (accept) begin
            budget_left <= budget_eff - 8'd1;
         end else if (win_wrap) begin
            budget_left <= MAX_B;
         end

         if (go_lock) begin
            st        <= ST_LOCKOUT;
            stim_out  <= 1'b0;
            lockout   <= 1'b1;
            phase_tmr <= '0;
         end else if (go_idle) begin
            st        <= ST_IDLE;
            stim_out  <= 1'b0;
            lockout   <= 1'b0;
            phase_tmr <= '0;
            win_tmr   <= '0;
         end else begin
            case (st)
               ST_IDLE: begin
                  stim_out  <= 1'b0;
                  lockout   <= 1'b0;
                  phase_tmr <= '0;
                  if (arm) begin
                     st          <= ST_ARMED;
                     budget_left <= MAX_B;
                  end
               end
               ST_ARMED: begin
                  if (accept) begin
                     st        <= ST_PULSE;
                     stim_out  <= 1'b1;
                     phase_tmr <= PW_LAST;
                  end
               end
               ST_PULSE: begin
                  if (phase_tmr == '0) begin
                     st        <= ST_REFRAC;
                     stim_out  <= 1'b0;
                     phase_tmr <= REFRAC_LAST;
                  end else begin
                     phase_tmr <= phase_tmr - CNT_ONE;
                  end
               end
               ST_REFRAC: begin
                  if (phase_tmr == '0) begin
                     st <= ST_ARMED;
                  end else begin
                     phase_tmr <= phase_tmr - CNT_ONE;
                  end
               end
               ST_LOCKOUT: begin
                  stim_out <= 1'b0;
                  lockout  <= 1'b1;
                  if (!arm && tier_ok) begin
                     st        <= ST_IDLE;
                     lockout   <= 1'b0;
                     phase_tmr <= '0;
                     win_tmr   <= '0;
                  end
               end
               default: begin
                  st        <= ST_IDLE;
                  stim_out  <= 1'b0;
                  lockout   <= 1'b0;
                  phase_tmr <= '0;
                  win_tmr   <= '0;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_boreal_stim_scheduler.sv
// Testbench for boreal_stim_scheduler with short timing parameters.
// Stimulus registers expected values against an absolute cycle number;
// a monitor compares them on the falling edge of that cycle.

module tb_boreal_stim_scheduler;

   localparam int PW  = 4;
   localparam int REF = 10;
   localparam int WIN = 100;
   localparam int MAXP = 2;

   localparam int S_STIM  = 0;
   localparam int S_STATE = 1;
   localparam int S_PCNT  = 2;
   localparam int S_DCNT  = 3;
   localparam int S_BUD   = 4;
   localparam int S_LOCK  = 5;

   logic       clk;
   logic       rst;
   logic       arm;
   logic       trigger;
   logic       phase_lock;
   logic       low_conf;
   logic [1:0] safety_tier;
   logic       stim_out;
   logic [2:0] state;
   logic [7:0] pulse_count;
   logic [7:0] drop_count;
   logic [7:0] budget_left;
   logic       lockout;

   boreal_stim_scheduler #(
      .PW_CYC     (PW),
      .REFRAC_CYC (REF),
      .WIN_CYC    (WIN),
      .MAX_PULSES (MAXP),
      .CNT_W      (32)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .arm         (arm),
      .trigger     (trigger),
      .phase_lock  (phase_lock),
      .low_conf    (low_conf),
      .safety_tier (safety_tier),
      .stim_out    (stim_out),
      .state       (state),
      .pulse_count (pulse_count),
      .drop_count  (drop_count),
      .budget_left (budget_left),
      .lockout     (lockout)
   );

   typedef struct {
      int    due;
      int    sig;
      int    exp;
      string name;
   } chk_t;

   chk_t sb[$];
   int   cyc = 0;
   int   n_pass = 0;
   int   n_total = 0;
   int   arm_cyc = 0;

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Cycle number: value after the N-th rising edge.
   always @(posedge clk) cyc <= cyc + 1;

   function automatic int get_sig(input int sig);
      case (sig)
         S_STIM:  return int'(stim_out);
         S_STATE: return int'(state);
         S_PCNT:  return int'(pulse_count);
         S_DCNT:  return int'(drop_count);
         S_BUD:   return int'(budget_left);
         default: return int'(lockout);
      endcase
   endfunction

   // Monitor: compare every expectation whose cycle has arrived.
   always @(negedge clk) begin
      for (int i = sb.size() - 1; i >= 0; i--) begin
         if (sb[i].due <= cyc) begin
            int act;
            act = get_sig(sb[i].sig);
            n_total++;
            if (sb[i].due == cyc && act == sb[i].exp) begin
               n_pass++;
            end else begin
               $display("FAIL %s @%0d: got %0d expected %0d (checked at %0d)",
                        sb[i].name, sb[i].due, act, sb[i].exp, cyc);
            end
            sb.delete(i);
         end
      end
   end

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic wait_until(input int c);
      while (cyc < c) @(negedge clk);
   endtask

   task automatic expect_at(input string name, input int sig, input int val, input int due);
      chk_t c;
      c.due  = due;
      c.sig  = sig;
      c.exp  = val;
      c.name = name;
      sb.push_back(c);
   endtask

   task automatic fire_at(input int c);
      wait_until(c);
      trigger = 1'b1;
      tick(1);
      trigger = 1'b0;
   endtask

   // Reset (with reset-value checks), then raise arm at cycle arm_cyc.
   task automatic reset_arm();
      rst = 1'b1; arm = 1'b0; trigger = 1'b0;
      phase_lock = 1'b1; low_conf = 1'b0; safety_tier = 2'd0;
      tick(2);
      expect_at("rst_state",  S_STATE, 0,    cyc + 1);
      expect_at("rst_stim",   S_STIM,  0,    cyc + 1);
      expect_at("rst_pcnt",   S_PCNT,  0,    cyc + 1);
      expect_at("rst_dcnt",   S_DCNT,  0,    cyc + 1);
      expect_at("rst_budget", S_BUD,   MAXP, cyc + 1);
      expect_at("rst_lock",   S_LOCK,  0,    cyc + 1);
      tick(1);
      rst = 1'b0;
      arm = 1'b1;
      arm_cyc = cyc;
      expect_at("arm_state", S_STATE, 1, cyc + 1);
      tick(2);
   endtask

   initial begin
      int s;
      int a;
      int c0;

      // 1: single pulse timing
      reset_arm();
      s = cyc;
      for (int k = 1; k <= 15; k++) begin
         expect_at("t1_stim",  S_STIM,  (k <= PW) ? 1 : 0, s + k);
         expect_at("t1_state", S_STATE, (k <= PW) ? 2 : ((k <= PW + REF) ? 3 : 1), s + k);
      end
      expect_at("t1_pcnt",   S_PCNT, 1, s + 1);
      expect_at("t1_budget", S_BUD,  1, s + 1);
      expect_at("t1_dcnt",   S_DCNT, 0, s + 15);
      fire_at(s);
      wait_until(s + 20);

      // 2: triggers during pulse and refractory are dropped
      reset_arm();
      s = cyc;
      expect_at("t2_stim_on",  S_STIM,  1, s + 4);
      expect_at("t2_stim_off", S_STIM,  0, s + 5);
      expect_at("t2_dcnt1",    S_DCNT,  1, s + 4);
      expect_at("t2_dcnt2",    S_DCNT,  2, s + 10);
      expect_at("t2_pcnt",     S_PCNT,  1, s + 15);
      expect_at("t2_state",    S_STATE, 1, s + 15);
      fire_at(s);
      fire_at(s + 2);
      fire_at(s + 8);
      wait_until(s + 20);

      // 3: pulse budget per window, reload at wrap, wrap coinciding with accept
      reset_arm();
      a = arm_cyc;
      expect_at("t3_bud_a",    S_BUD,  1, a + 3);
      expect_at("t3_bud_b",    S_BUD,  0, a + 23);
      expect_at("t3_pcnt_b",   S_PCNT, 2, a + 23);
      expect_at("t3_dcnt_c",   S_DCNT, 1, a + 43);
      expect_at("t3_stim_c",   S_STIM, 0, a + 43);
      expect_at("t3_bud_c",    S_BUD,  0, a + 43);
      expect_at("t3_bud_prew", S_BUD,  0, a + 100);
      expect_at("t3_bud_wrap", S_BUD,  2, a + 101);
      expect_at("t3_stim_d",   S_STIM, 1, a + 111);
      expect_at("t3_bud_d",    S_BUD,  1, a + 111);
      expect_at("t3_bud_e",    S_BUD,  0, a + 131);
      expect_at("t3_bud_pre2", S_BUD,  0, a + 200);
      expect_at("t3_stim_wa",  S_STIM, 1, a + 201);
      expect_at("t3_bud_wa",   S_BUD,  1, a + 201);
      expect_at("t3_pcnt_wa",  S_PCNT, 5, a + 201);
      fire_at(a + 2);
      fire_at(a + 22);
      fire_at(a + 42);
      fire_at(a + 110);
      fire_at(a + 130);
      fire_at(a + 200);
      wait_until(a + 220);

      // 4: safety tier truncates pulse, lockout exit only via IDLE
      reset_arm();
      s = cyc;
      expect_at("t4_stim_on",   S_STIM,  1, s + 2);
      expect_at("t4_stim_cut",  S_STIM,  0, s + 3);
      expect_at("t4_state_lo",  S_STATE, 4, s + 3);
      expect_at("t4_lockout",   S_LOCK,  1, s + 3);
      expect_at("t4_state_lo2", S_STATE, 4, s + 4);
      expect_at("t4_dcnt_lo",   S_DCNT,  1, s + 6);
      expect_at("t4_stay_lo",   S_STATE, 4, s + 7);
      expect_at("t4_stim_lo",   S_STIM,  0, s + 7);
      expect_at("t4_idle",      S_STATE, 0, s + 9);
      expect_at("t4_lock_clr",  S_LOCK,  0, s + 9);
      expect_at("t4_rearm",     S_STATE, 1, s + 11);
      fire_at(s);
      wait_until(s + 2);
      safety_tier = 2'd2;
      wait_until(s + 5);
      safety_tier = 2'd0;
      fire_at(s + 5);
      wait_until(s + 8);
      arm = 1'b0;
      wait_until(s + 10);
      arm = 1'b1;
      wait_until(s + 15);

      // 5: no lock / low confidence rejects trigger
      reset_arm();
      s = cyc;
      expect_at("t5_dcnt_nolock", S_DCNT,  1, s + 1);
      expect_at("t5_stim_nolock", S_STIM,  0, s + 1);
      expect_at("t5_state",       S_STATE, 1, s + 1);
      expect_at("t5_dcnt_lowc",   S_DCNT,  2, s + 3);
      expect_at("t5_stim_lowc",   S_STIM,  0, s + 3);
      expect_at("t5_pcnt0",       S_PCNT,  0, s + 3);
      expect_at("t5_stim_ok",     S_STIM,  1, s + 6);
      expect_at("t5_pcnt_ok",     S_PCNT,  1, s + 6);
      expect_at("t5_dcnt_ok",     S_DCNT,  2, s + 6);
      phase_lock = 1'b0;
      fire_at(s);
      phase_lock = 1'b1;
      low_conf = 1'b1;
      fire_at(s + 2);
      low_conf = 1'b0;
      fire_at(s + 5);
      wait_until(s + 25);

      // 6: disarm truncates pulse; drop counter saturates
      reset_arm();
      s = cyc;
      expect_at("t6_stim_on",  S_STIM,  1, s + 2);
      expect_at("t6_stim_cut", S_STIM,  0, s + 3);
      expect_at("t6_idle",     S_STATE, 0, s + 3);
      expect_at("t6_dcnt0",    S_DCNT,  0, s + 5);
      fire_at(s);
      wait_until(s + 2);
      arm = 1'b0;
      wait_until(s + 4);
      phase_lock = 1'b0;
      arm = 1'b1;
      wait_until(s + 6);
      c0 = cyc;
      expect_at("t6_dcnt254", S_DCNT,  254, c0 + 254);
      expect_at("t6_dcnt255", S_DCNT,  255, c0 + 255);
      expect_at("t6_dcnt_sat", S_DCNT, 255, c0 + 300);
      expect_at("t6_pcnt",    S_PCNT,  1,   c0 + 300);
      expect_at("t6_state",   S_STATE, 1,   c0 + 300);
      trigger = 1'b1;
      wait_until(c0 + 300);
      trigger = 1'b0;

      for (int i = 0; i < 50 && sb.size() != 0; i++) tick(1);
      if (sb.size() != 0) begin
         $display("FAIL pending: %0d expectations never checked, required 0", sb.size());
         n_total += sb.size();
      end
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not reach summary, passed %0d of %0d", n_pass, n_total);
      $fatal(1, "timeout");
   end

endmodule
